// File: rtl/mtip_if_cfg.sv
// mtip_if_cfg: MTIP receive primitive bit positions and the FC-1 link state encoding.
package mtip_if_cfg;

   localparam int unsigned MTIP_PRIM_W    = 12;

   // One-hot primitive flags; bits not listed here flag other ordered sets.
   localparam int unsigned MTIP_PRIM_IDLE = 0;
   localparam int unsigned MTIP_PRIM_NOS  = 5;
   localparam int unsigned MTIP_PRIM_OLS  = 6;
   localparam int unsigned MTIP_PRIM_LR   = 7;
   localparam int unsigned MTIP_PRIM_LRR  = 8;

   typedef enum logic [1:0] {
      LINK_DOWN      = 2'd0,
      LINK_IDLE_WAIT = 2'd1,
      LINK_UP        = 2'd2,
      LINK_FAULT     = 2'd3
   } fc1_link_state_e;

endpackage

// File: rtl/fc1_link_fsm.sv
// fc1_link_fsm: one channel's link-state FSM with IDLE debounce and a one-cycle link-up event.
module fc1_link_fsm
   import mtip_if_cfg::*;
#(
   parameter int unsigned IDLE_DEBOUNCE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [MTIP_PRIM_W-1:0] iPRIM,
   input  logic                   iVALID,
   output logic [1:0]             oSTATE,
   output logic                   oLINK_UP_EVENT
);

   localparam logic [7:0]             DEB       = 8'(IDLE_DEBOUNCE);
   localparam logic [MTIP_PRIM_W-1:0] IDLE_MASK = MTIP_PRIM_W'(1) << MTIP_PRIM_IDLE;

   fc1_link_state_e state, stateNext;
   logic [7:0]      idleCnt, idleCntNext;
   logic            nosOlsPrev, lrLrrPrev, enterUpQ;
   logic            otherPrim, isIdle, nosOls, lrLrr, faultRise, enterUp;

   always_comb begin
      otherPrim = |(iPRIM & ~IDLE_MASK);
      isIdle    = iPRIM[MTIP_PRIM_IDLE] & ~otherPrim;
      nosOls    = iPRIM[MTIP_PRIM_NOS] | iPRIM[MTIP_PRIM_OLS];
      lrLrr     = iPRIM[MTIP_PRIM_LR] | iPRIM[MTIP_PRIM_LRR];
      faultRise = (nosOls & ~nosOlsPrev) | (lrLrr & ~lrLrrPrev);
   end

   always_comb begin
      stateNext   = state;
      idleCntNext = idleCnt;
      unique case (state)
         LINK_DOWN, LINK_FAULT: begin
            if (!iVALID) begin
               stateNext   = LINK_DOWN;
               idleCntNext = '0;
            end else if (isIdle) begin
               if (DEB == 8'd1) begin
                  stateNext   = LINK_UP;
                  idleCntNext = '0;
               end else begin
                  stateNext   = LINK_IDLE_WAIT;
                  idleCntNext = 8'd1;
               end
            end
         end
         LINK_IDLE_WAIT: begin
            if (!iVALID || otherPrim) begin
               stateNext   = LINK_DOWN;
               idleCntNext = '0;
            end else if (isIdle) begin
               if (idleCnt + 8'd1 == DEB) begin
                  stateNext   = LINK_UP;
                  idleCntNext = '0;
               end else begin
                  idleCntNext = idleCnt + 8'd1;
               end
            end
         end
         LINK_UP: begin
            if (!iVALID)        stateNext = LINK_DOWN;
            else if (faultRise) stateNext = LINK_FAULT;
         end
      endcase
      enterUp = (stateNext == LINK_UP) && (state != LINK_UP);
   end

   // Entry is staged through enterUpQ so the event trails the UP state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= LINK_DOWN;
         idleCnt        <= '0;
         nosOlsPrev     <= 1'b0;
         lrLrrPrev      <= 1'b0;
         enterUpQ       <= 1'b0;
         oLINK_UP_EVENT <= 1'b0;
      end else begin
         state          <= stateNext;
         idleCnt        <= idleCntNext;
         nosOlsPrev     <= nosOls;
         lrLrrPrev      <= lrLrr;
         enterUpQ       <= enterUp;
         oLINK_UP_EVENT <= enterUpQ;
      end
   end

   assign oSTATE = state;

endmodule

// File: rtl/vi_sync_level.sv
// vi_sync_level: two-flop synchroniser for asynchronous level inputs.
module vi_sync_level #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] iLEVEL,
   output logic [WIDTH-1:0] oLEVEL
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= '0;
         oLEVEL <= '0;
      end else begin
         meta   <= iLEVEL;
         oLEVEL <= meta;
      end
   end

endmodule

// File: rtl/fc1_link_stats_mc.sv
// fc1_link_stats_mc: multi-channel FC-1 link tracking with latched interval statistics.
// Define FC1_STATS_SATURATE_EN to make live counters saturate instead of wrapping.
module fc1_link_stats_mc
   import mtip_if_cfg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CTR_W         = 32,
   parameter int unsigned IDLE_DEBOUNCE = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH*MTIP_PRIM_W-1:0] iRX_PRIMITIVE,
   input  logic [NUM_CH-1:0]             iRX_DISP_ERR,
   input  logic [NUM_CH-1:0]             iRX_CHAR_ERR,
   input  logic [NUM_CH-1:0]             iRX_SOF,
   input  logic [NUM_CH-1:0]             iRX_EOF,
   input  logic [NUM_CH-1:0]             iFC_LINK_SYNC,
   input  logic [NUM_CH-1:0]             iSFP_PHY_LOSIG,
   input  logic                          iSTATS_LATCH_CLR,
   output logic [NUM_CH*CTR_W-1:0]       oINT_STATS_FC_CODE,
   output logic [NUM_CH*CTR_W-1:0]       oINT_STATS_FRM_ERR,
   output logic [NUM_CH*CTR_W-1:0]       oINT_STATS_LINK_UP,
   output logic [NUM_CH-1:0]             oLINK_UP_EVENT,
   output logic [NUM_CH*2-1:0]           oLINK_STATE
);

   logic [NUM_CH*MTIP_PRIM_W-1:0] primQ;
   logic [NUM_CH-1:0]             dispQ, charQ, sofQ, eofQ;
   logic                          latchQ;
   logic [NUM_CH-1:0]             syncS, losigS, valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primQ  <= '0;
         dispQ  <= '0;
         charQ  <= '0;
         sofQ   <= '0;
         eofQ   <= '0;
         latchQ <= 1'b0;
      end else begin
         primQ  <= iRX_PRIMITIVE;
         dispQ  <= iRX_DISP_ERR;
         charQ  <= iRX_CHAR_ERR;
         sofQ   <= iRX_SOF;
         eofQ   <= iRX_EOF;
         latchQ <= iSTATS_LATCH_CLR;
      end
   end

   vi_sync_level #(.WIDTH(2*NUM_CH)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .iLEVEL ({iSFP_PHY_LOSIG, iFC_LINK_SYNC}),
      .oLEVEL ({losigS, syncS})
   );

   assign valid = syncS & ~losigS;

   function automatic logic [CTR_W-1:0] bump(input logic [CTR_W-1:0] v, input logic inc);
`ifdef FC1_STATS_SATURATE_EN
      bump = (inc && (v != '1)) ? v + CTR_W'(1) : v;
`else
      bump = v + CTR_W'(inc);
`endif
   endfunction

   genvar c;
   for (c = 0; c < int'(NUM_CH); c++) begin : g_ch
      logic             frmOpen, frmOpenNext, frmErr;
      logic [2:0]       inc;
      logic [CTR_W-1:0] live [3];
      logic [CTR_W-1:0] held [3];

      fc1_link_fsm #(.IDLE_DEBOUNCE(IDLE_DEBOUNCE)) u_fsm (
         .clk            (clk),
         .rst_n          (rst_n),
         .iPRIM          (primQ[c*MTIP_PRIM_W +: MTIP_PRIM_W]),
         .iVALID         (valid[c]),
         .oSTATE         (oLINK_STATE[2*c +: 2]),
         .oLINK_UP_EVENT (oLINK_UP_EVENT[c])
      );

      // A same-cycle SOF+EOF is a complete short frame: no error, nothing left open.
      always_comb begin
         frmErr      = 1'b0;
         frmOpenNext = frmOpen;
         if (sofQ[c] && eofQ[c]) begin
            frmOpenNext = 1'b0;
         end else if (sofQ[c]) begin
            frmErr      = frmOpen;
            frmOpenNext = 1'b1;
         end else if (eofQ[c]) begin
            frmErr      = ~frmOpen;
            frmOpenNext = 1'b0;
         end
      end

      assign inc = {oLINK_UP_EVENT[c], frmErr, valid[c] & (dispQ[c] | charQ[c])};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            frmOpen <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
               live[i] <= '0;
               held[i] <= '0;
            end
         end else begin
            frmOpen <= frmOpenNext;
            for (int unsigned i = 0; i < 3; i++) begin
               if (latchQ) begin
                  held[i] <= live[i];
                  live[i] <= CTR_W'(inc[i]);
               end else begin
                  live[i] <= bump(live[i], inc[i]);
               end
            end
         end
      end

      assign oINT_STATS_FC_CODE[c*CTR_W +: CTR_W] = held[0];
      assign oINT_STATS_FRM_ERR[c*CTR_W +: CTR_W] = held[1];
      assign oINT_STATS_LINK_UP[c*CTR_W +: CTR_W] = held[2];
   end

endmodule
